// File: rtl/byte_packer.sv
// byte_packer: packs INPUT-byte samples into OUTPUT-byte words through a
// BUF_BYTES byte buffer, with a per-byte disable mask and optional flush.
// Ports: clk_i, rst_in (async, active-low), cfg_stb_i/cfg_i (byte-disable mask),
//   stb_i/rdy_o/d_i (sample in), flush_i, stb_o/rdy_i/q_o/keep_o/last_o (word out),
//   ovf_o (sticky overflow), fill_o (bytes buffered).
// Macro BYTE_PACKER_FLUSH_EN enables flush_i, the FLUSH state and last_o.
module byte_packer #(
  parameter int INPUT     = 4,
  parameter int OUTPUT    = 4,
  parameter int BUF_BYTES = 2 * (INPUT + OUTPUT)
) (
  input  logic                           clk_i,
  input  logic                           rst_in,
  input  logic                           cfg_stb_i,
  input  logic [INPUT-1:0]               cfg_i,
  input  logic                           stb_i,
  output logic                           rdy_o,
  input  logic [INPUT*8-1:0]             d_i,
  input  logic                           flush_i,
  output logic                           stb_o,
  input  logic                           rdy_i,
  output logic [OUTPUT*8-1:0]            q_o,
  output logic [OUTPUT-1:0]              keep_o,
  output logic                           last_o,
  output logic                           ovf_o,
  output logic [$clog2(BUF_BYTES+1)-1:0] fill_o
);

  localparam int FW = $clog2(BUF_BYTES + 1);

  generate
    if (BUF_BYTES < INPUT + OUTPUT) begin : g_bad_buf
      $error("byte_packer: BUF_BYTES must be >= INPUT+OUTPUT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_FLUSH
  } state_e;

  state_e           state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [7:0]       buf_q [BUF_BYTES];
  logic [7:0]       buf_d [BUF_BYTES];
  logic [INPUT-1:0] cfg_q, cfg_d;
  logic             ovf_q, ovf_d;

  logic in_flush;
  logic full_word;
  logic push;
  logic drop;
  logic pop;
  int   fill_n;
  int   nadd;
  int   pop_n;

`ifdef BYTE_PACKER_FLUSH_EN
  assign in_flush = (state_q == S_FLUSH);
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign in_flush = 1'b0;
`endif

  assign fill_n    = int'(fill_q);
  assign full_word = (fill_n >= OUTPUT);

  // rdy_o looks only at registered state, never at rdy_i.
  assign rdy_o = ((BUF_BYTES - fill_n) >= INPUT) && !in_flush;
  assign stb_o = full_word || (in_flush && (fill_n != 0));
  assign push  = stb_i && rdy_o;
  assign drop  = stb_i && !rdy_o;
  assign pop   = stb_o && rdy_i;

  // A partial word only ever pops during a flush; it takes everything.
  assign pop_n = full_word ? OUTPUT : fill_n;

  always_comb begin
    nadd = 0;
    for (int i = 0; i < INPUT; i++) begin
      if (!cfg_q[i]) nadd = nadd + 1;
    end
  end

  always_comb begin
    keep_o = '0;
    q_o    = '0;
    for (int k = 0; k < OUTPUT; k++) begin
      keep_o[k] = stb_o && (k < fill_n);
      if (keep_o[k]) q_o[8*k +: 8] = buf_q[k];
    end
  end

  assign last_o = in_flush && stb_o && (fill_n <= OUTPUT);
  assign ovf_o  = ovf_q;
  assign fill_o = fill_q;

  // Buffer is kept oldest-first at index 0; a pop shifts down, then
  // enabled input bytes are appended after what remains.
  always_comb begin
    int shift;
    int base;
    int off;
    shift = pop ? pop_n : 0;
    base  = fill_n - shift;
    off   = 0;
    for (int j = 0; j < BUF_BYTES; j++) begin
      buf_d[j] = 8'h00;
    end
    for (int s = 0; s < BUF_BYTES; s++) begin
      if (s >= shift) buf_d[s - shift] = buf_q[s];
    end
    for (int i = 0; i < INPUT; i++) begin
      if (push && !cfg_q[i]) begin
        buf_d[base + off] = d_i[8*i +: 8];
        off = off + 1;
      end
    end
    fill_d = FW'(base + (push ? nadd : 0));
  end

  always_comb begin
    cfg_d = cfg_stb_i ? cfg_i : cfg_q;
    ovf_d = (ovf_q && !cfg_stb_i) || drop;
  end

  always_comb begin
    state_d = (fill_d != '0) ? S_FILL : S_IDLE;
`ifdef BYTE_PACKER_FLUSH_EN
    unique case (1'b1)
      (state_q == S_FLUSH): begin
        state_d = (pop && last_o) ? S_IDLE : S_FLUSH;
      end
      (state_q == S_FILL): begin
        if (flush_i && (fill_d != '0)) state_d = S_FLUSH;
      end
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      fill_q  <= '0;
      cfg_q   <= '0;
      ovf_q   <= 1'b0;
      for (int j = 0; j < BUF_BYTES; j++) begin
        buf_q[j] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      cfg_q   <= cfg_d;
      ovf_q   <= ovf_d;
      for (int j = 0; j < BUF_BYTES; j++) begin
        buf_q[j] <= buf_d[j];
      end
    end
  end

endmodule

// File: doc/byte_packer.md
BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 SHALL have parameter INPUT, default 4, number of input bytes per sample.
REQ-002 SHALL have parameter OUTPUT, default 4, number of output bytes per word.
REQ-003 SHALL have parameter BUF_BYTES, default 2*(INPUT+OUTPUT), buffer capacity in bytes; elaboration error if BUF_BYTES < INPUT+OUTPUT.
REQ-004 clk_i  in  1  system clock; the only clock, all state on rising edge.
REQ-005 rst_in  in  1  reset, asynchronous, active-low.
REQ-006 cfg_stb_i  in  1  configuration strobe; cfg_i valid.
REQ-007 cfg_i  in  INPUT  byte-disable mask; bit i=1 drops byte i of d_i.
REQ-008 stb_i  in  1  input sample valid.
REQ-009 rdy_o  out  1  packer can accept a full sample.
REQ-010 d_i  in  INPUT*8  input sample, byte i = d_i[8i+7:8i].
REQ-011 flush_i  in  1  single-cycle request to drain a partial word.
REQ-012 stb_o  out  1  output word valid.
REQ-013 rdy_i  in  1  downstream accepts word.
REQ-014 q_o  out  OUTPUT*8  output word.
REQ-015 keep_o  out  OUTPUT  valid-byte mask of q_o.
REQ-016 last_o  out  1  final word of a flush.
REQ-017 ovf_o  out  1  sticky overflow flag.
REQ-018 fill_o  out  $clog2(BUF_BYTES+1)  bytes currently buffered.

Function
REQ-019 Input accepted on an edge where stb_i && rdy_o; enabled bytes (cfg bit 0) appended in ascending index order.
REQ-020 Output word: oldest buffered byte at q_o[7:0], next at q_o[15:8], etc.
REQ-021 rdy_o = (BUF_BYTES - fill) >= INPUT and not in FLUSH; depends on registered state only, no combinational path from rdy_i.
REQ-022 stb_o asserted whenever fill >= OUTPUT (keep_o all ones), or in FLUSH with fill > 0.
REQ-023 Word popped on edge where stb_o && rdy_i; q_o, keep_o, last_o held stable while stb_o && !rdy_i.
REQ-024 Simultaneous push and pop on one edge: both applied; fill_next = fill + enabled_bytes - popped.
REQ-025 Latency: bytes completing a word at edge N give stb_o=1 in cycle after N.
REQ-026 stb_i while !rdy_o: sample dropped, ovf_o set; cleared only by reset or cfg_stb_i.
REQ-027 cfg_stb_i loads mask on next edge; affects samples accepted from the following edge; buffered bytes untouched.
REQ-028 cfg_i all ones: accepted samples add no bytes, rdy_o unaffected.
REQ-029 States: IDLE (fill=0), FILL (fill>0), FLUSH.
REQ-030 IDLE->FILL on push adding bytes; FILL->IDLE when fill reaches 0; flush_i in IDLE with fill=0 ignored.
REQ-031 flush_i in FILL -> FLUSH; no input accepted in FLUSH.
REQ-032 In FLUSH, full words emitted normally; final word with fill < OUTPUT zero-padded, keep_o low bits set per byte count; last_o=1 on final word only.
REQ-033 FLUSH->IDLE on pop of the last_o word; flush_i during FLUSH ignored.
REQ-034 Output/unused q_o bytes drive zero when stb_o=0.

Reset
REQ-035 On rst_in low: state IDLE, fill_o 0, buffer 0, mask 0 (all enabled), ovf_o 0, stb_o 0, q_o 0, keep_o 0, last_o 0, rdy_o 1 after release.
REQ-036 Reset mid-FLUSH or with stb_o pending discards all buffered data with no further output.

Configuration
REQ-037 Macro BYTE_PACKER_FLUSH_EN defined: flush_i, FLUSH state, last_o behave per REQ-031..033.
REQ-038 Macro undefined: flush_i ignored, FLUSH unreachable, last_o tied 0, keep_o all ones whenever stb_o=1; partial bytes wait indefinitely.

Verification (INPUT=4, OUTPUT=4, BUF_BYTES=16)
REQ-039 Mask 0, d_i=0x44332211 then 0x88776655, rdy_i=1 -> q_o 0x44332211 then 0x88776655, each one cycle after accept.
REQ-040 Mask 0b1010, samples 0x__BB__AA, 0x__DD__CC -> single word q_o=0xDDCCBBAA after second sample.
REQ-041 rdy_i=0, push 0x0..0x3 samples -> rdy_o low at fill 16 (4 samples accepted); fifth stb_i sets ovf_o=1, data lost; cfg_stb_i clears ovf_o.
REQ-042 FLUSH_EN, mask 0b1100, push 0xXXXX2211, 0xXXXX4433, 0xXXXX6655, flush_i -> 0x44332211 keep 1111 last 0, then 0x00006655 keep 0011 last 1, state IDLE.
REQ-043 stb_o held with rdy_i=0 for 5 cycles while pushing -> q_o/keep_o stable, no byte lost or reordered.
REQ-044 rst_in low during FLUSH with fill 3 -> all outputs 0 immediately, no word emitted after release.
